// File: rtl/req_fifo_reader_if.sv
// Handshake bundle between the request FIFO read port, the reader engine and
// the PHY-lane transmit interface.
interface req_fifo_reader_if #(
  parameter int WIDTH = 64
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_rd;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_sop;
  logic             tx_eop;
  logic             tx_ready;

  // master: the reader engine; slave: FIFO plus downstream lane
  modport master (
    input  fifo_empty, fifo_rdata, tx_ready,
    output fifo_rd, tx_data, tx_valid, tx_sop, tx_eop
  );

  modport slave (
    output fifo_empty, fifo_rdata, tx_ready,
    input  fifo_rd, tx_data, tx_valid, tx_sop, tx_eop
  );
endinterface

// File: rtl/req_fifo_reader.sv
// Drains header-framed request words from a show-ahead FIFO onto a valid/ready
// transmit lane; malformed headers are dropped and counted.
module req_fifo_reader #(
  parameter int          WIDTH = 64,
  parameter logic [7:0]  DELIM = 8'hee,
  parameter int          LEN_W = 8,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  req_fifo_reader_if.master bus,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  typedef enum logic {
    HDR     = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  state_t           state_p0;
  logic [LEN_W-1:0] rem_p0;
  logic [WIDTH-1:0] tx_data_p0;
  logic             vld_p0;
  logic             sop_p0;
  logic             eop_p0;
  logic [CNT_W-1:0] err_p0;

  logic             hdr_bad;
  logic [LEN_W-1:0] hdr_len;
  logic             slot_free;
  logic             pop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A bad header can be dropped even while the output slot is stalled.
  always_comb begin
    hdr_bad   = (bus.fifo_rdata[7:0] != DELIM);
    hdr_len   = bus.fifo_rdata[8 +: LEN_W];
    slot_free = ~vld_p0 | bus.tx_ready;
    pop       = ~reset & ~bus.fifo_empty &
                (slot_free | ((state_p0 == HDR) & hdr_bad));
  end

  // ---- stage p0: output register, parser state, error counter ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0   <= HDR;
      rem_p0     <= '0;
      tx_data_p0 <= '0;
      vld_p0     <= 1'b0;
      sop_p0     <= 1'b0;
      eop_p0     <= 1'b0;
      err_p0     <= '0;
    end else begin
      if (vld_p0 & bus.tx_ready)
        vld_p0 <= 1'b0;
      if (pop) begin
        if (state_p0 == HDR) begin
          if (hdr_bad) begin
            err_p0 <= sat_inc(err_p0);
          end else begin
            tx_data_p0 <= bus.fifo_rdata;
            vld_p0     <= 1'b1;
            sop_p0     <= 1'b1;
            if (hdr_len == '0) begin
              eop_p0 <= 1'b1;
            end else begin
              eop_p0   <= 1'b0;
              rem_p0   <= hdr_len;
              state_p0 <= PAYLOAD;
            end
          end
        end else begin
          tx_data_p0 <= bus.fifo_rdata;
          vld_p0     <= 1'b1;
          sop_p0     <= 1'b0;
          eop_p0     <= (rem_p0 == LEN_W'(1));
          rem_p0     <= rem_p0 - LEN_W'(1);
          if (rem_p0 == LEN_W'(1))
            state_p0 <= HDR;
        end
      end
    end
  end

  assign bus.fifo_rd  = pop;
  assign bus.tx_data  = tx_data_p0;
  assign bus.tx_valid = vld_p0;
  assign bus.tx_sop   = sop_p0;
  assign bus.tx_eop   = eop_p0;
  assign err_cnt      = err_p0;
  assign busy         = (state_p0 == PAYLOAD) | vld_p0;

endmodule

// File: tb/tb_req_fifo_reader.sv
// Bench for req_fifo_reader: queue-modelled FIFO, expected-beat scoreboard,
// a header vector table and hand-written multi-cycle sequences.
module tb_req_fifo_reader;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  req_fifo_reader_if #(.WIDTH(64)) bus ();
  req_fifo_reader_if #(.WIDTH(64)) bus2 ();
  logic [15:0] err_cnt;
  logic        busy;
  logic [3:0]  err2;
  logic        busy2;

  req_fifo_reader dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err_cnt (err_cnt),
    .busy    (busy)
  );

  req_fifo_reader #(.CNT_W(4)) dut2 (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus2),
    .err_cnt (err2),
    .busy    (busy2)
  );

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
  } beat_t;

  typedef struct {
    logic        push;
    logic [63:0] word;
    logic        good;
    logic        exp_rd;
    logic        exp_v;
    logic        exp_sop;
    logic        exp_eop;
    int          exp_err;
  } vec_t;

  logic [63:0] q[$];
  beat_t       sb[$];
  vec_t        tbl[9];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rd_cnt, acc_cnt, first_acc, last_acc;
  int exp_err = 0;
  logic last_rd;
  logic hold_pend = 1'b0;
  beat_t hold_b;

  function automatic logic [63:0] hdr(input logic [7:0] len, input logic [47:0] up);
    return {up, len, 8'hee};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_msg(input int len, input logic [47:0] up);
    logic [63:0] w;
    w = hdr(8'(len), up);
    q.push_back(w);
    sb.push_back('{w, 1'b1, (len == 0)});
    for (int i = 0; i < len; i++) begin
      w = {up, 8'(i), 8'h12};
      q.push_back(w);
      sb.push_back('{w, 1'b0, (i == len - 1)});
    end
  endtask

  // One clock: present FIFO head, sample before the edge, pop on the edge.
  task automatic step();
    beat_t e;
    logic [63:0] tmp;
    bus.fifo_empty = (q.size() == 0);
    bus.fifo_rdata = (q.size() == 0) ? 64'h0 : q[0];
    #2;
    last_rd = bus.fifo_rd;
    if (bus.fifo_empty)
      chk("empty_guard_rd", bus.fifo_rd, 0);
    if (hold_pend) begin
      chk("hold_valid", bus.tx_valid, 1);
      chk("hold_data", bus.tx_data, hold_b.d);
      chk("hold_sop_eop", {bus.tx_sop, bus.tx_eop}, {hold_b.sop, hold_b.eop});
    end
    hold_pend = bus.tx_valid & ~bus.tx_ready;
    hold_b    = '{bus.tx_data, bus.tx_sop, bus.tx_eop};
    if (bus.tx_valid && bus.tx_ready) begin
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_beat: got %0h want none", bus.tx_data);
      end else begin
        e = sb.pop_front();
        chk("beat_data", bus.tx_data, e.d);
        chk("beat_sop", bus.tx_sop, e.sop);
        chk("beat_eop", bus.tx_eop, e.eop);
      end
    end
    if (last_rd) rd_cnt++;
    @(posedge clk);
    if (last_rd && q.size() != 0) tmp = q.pop_front();
    cyc++;
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    bus.tx_ready = 1'b1;
    while ((q.size() != 0 || sb.size() != 0 || bus.tx_valid) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending beats want 0", sb.size());
    end
  endtask

  task automatic clr_stats();
    rd_cnt = 0;
    acc_cnt = 0;
    first_acc = -1;
    last_acc = -1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] w[5];
    logic [63:0] hd;

    tbl[0] = '{1'b0, 64'h0,                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1] = '{1'b1, hdr(8'd0, 48'h1234),        1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[2] = '{1'b1, 64'h0000_0000_0000_0012,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    tbl[3] = '{1'b1, hdr(8'd0, 48'hffff_ffff_ffff), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    tbl[4] = '{1'b1, 64'h0000_0000_0000_00ef,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    tbl[5] = '{1'b1, 64'h0000_0000_0000_0000,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3};
    tbl[6] = '{1'b0, 64'h0,                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3};
    tbl[7] = '{1'b1, hdr(8'd0, 48'h0000_a5a5),   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3};
    tbl[8] = '{1'b1, 64'h0000_0000_0000_ee00,    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4};

    reset           = 1'b1;
    bus.tx_ready    = 1'b1;
    bus.fifo_empty  = 1'b0;
    bus.fifo_rdata  = hdr(8'd0, 48'h0);
    bus2.tx_ready   = 1'b1;
    bus2.fifo_empty = 1'b1;
    bus2.fifo_rdata = 64'h0;
    clr_stats();

    #3;
    chk("rst_fifo_rd", bus.fifo_rd, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_sop_eop", {bus.tx_sop, bus.tx_eop}, 2'b00);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.fifo_empty = 1'b1;

    // header vector table, one word per cycle, tx_ready high
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].push) begin
        q.push_back(tbl[i].word);
        if (tbl[i].good) sb.push_back('{tbl[i].word, 1'b1, 1'b1});
      end
      step();
      chk($sformatf("tbl%0d_rd", i), last_rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_valid", i), bus.tx_valid, tbl[i].exp_v);
      if (tbl[i].exp_v)
        chk($sformatf("tbl%0d_sop_eop", i), {bus.tx_sop, bus.tx_eop},
            {tbl[i].exp_sop, tbl[i].exp_eop});
      chk($sformatf("tbl%0d_err", i), err_cnt, tbl[i].exp_err);
    end
    exp_err = 4;
    drain(10);

    // single message, len=2
    clr_stats();
    push_msg(2, 48'h0001_0002_0003);
    drain(20);
    chk("single_rd_cycles", rd_cnt, 3);
    chk("single_beats", acc_cnt, 3);
    chk("single_consecutive", last_acc - first_acc, 2);

    // zero-length back to back
    clr_stats();
    push_msg(0, 48'h0000_0000_00aa);
    push_msg(0, 48'h0000_0000_00bb);
    drain(20);
    chk("zlen_beats", acc_cnt, 2);
    chk("zlen_consecutive", last_acc - first_acc, 1);
    chk("zlen_idle_busy", busy, 0);

    // backpressure mid-payload
    clr_stats();
    push_msg(3, 48'h0bac_0bac_0bac);
    bus.tx_ready = 1'b1;
    step();
    step();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_rd", last_rd, 0);
    end
    drain(20);
    chk("bp_beats", acc_cnt, 4);
    chk("bp_rd_cycles", rd_cnt, 4);

    // malformed header ahead of a good message
    clr_stats();
    q.push_back(64'hdead_beef_0000_0012);
    exp_err++;
    push_msg(1, 48'h00c0_ffee_0000);
    drain(20);
    chk("bad_err_cnt", err_cnt, exp_err);
    chk("bad_beats", acc_cnt, 2);

    // FIFO drains mid-message
    clr_stats();
    hd = hdr(8'd4, 48'h0000_0e0e_0e0e);
    w[0] = hd;
    for (int i = 1; i < 5; i++) w[i] = {48'h0000_7777_0000, 8'(i), 8'hee};
    sb.push_back('{w[0], 1'b1, 1'b0});
    for (int i = 1; i < 5; i++) sb.push_back('{w[i], 1'b0, (i == 4)});
    q.push_back(w[0]);
    q.push_back(w[1]);
    q.push_back(w[2]);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("starve_busy", busy, 1);
    chk("starve_valid", bus.tx_valid, 0);
    chk("starve_rd", bus.fifo_rd, 0);
    q.push_back(w[3]);
    q.push_back(w[4]);
    drain(20);
    chk("starve_beats", acc_cnt, 5);

    // reset while in PAYLOAD with two payload words outstanding
    clr_stats();
    push_msg(3, 48'h0000_0000_4e57);
    bus.tx_ready = 1'b1;
    step();
    step();
    bus.fifo_empty = (q.size() == 0);
    bus.fifo_rdata = q[0];
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_fifo_rd", bus.fifo_rd, 0);
    chk("mid_rst_valid", bus.tx_valid, 0);
    chk("mid_rst_data", bus.tx_data, 0);
    chk("mid_rst_sop_eop", {bus.tx_sop, bus.tx_eop}, 2'b00);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_busy", busy, 0);
    q.delete();
    sb.delete();
    hold_pend = 1'b0;
    exp_err = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clr_stats();
    push_msg(0, 48'h0000_0000_0aaa);
    push_msg(1, 48'h0000_0000_0bbb);
    drain(20);
    chk("post_rst_beats", acc_cnt, 3);
    chk("post_rst_err", err_cnt, exp_err);

    // error counter saturation on a 4-bit counter instance
    bus2.fifo_rdata = 64'h0000_0000_0000_0055;
    bus2.fifo_empty = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("sat_err_14", err2, 14);
    chk("sat_drop_rd", bus2.fifo_rd, 1);
    @(posedge clk);
    #1;
    chk("sat_err_15", err2, 15);
    repeat (6) @(posedge clk);
    #1;
    chk("sat_err_hold", err2, 15);
    chk("sat_no_output", bus2.tx_valid, 0);
    bus2.fifo_empty = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/req_fifo_reader.md
# req_fifo_reader

Read-side engine for the request FIFO: drains 64-bit request words through the FIFO's show-ahead read port and presents them as framed messages on a valid/ready transmit interface toward the PHY lane. Each message is one header word carrying the 8'hee delimiter and a payload length, followed by that many payload words. Words whose header is malformed are discarded and counted. The block guards every pop against an empty FIFO; the FIFO itself does not protect against a pop when empty.

## Interface
- WIDTH, 64, request word width
- DELIM, 8'hee, required value of header bits [7:0]
- LEN_W, 8, payload-length field width, located at header bits [8+LEN_W-1:8]
- CNT_W, 16, error counter width
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- fifo_empty  in  1  FIFO empty flag
- fifo_rdata  in  WIDTH  FIFO head word, valid whenever fifo_empty=0
- fifo_rd  out  1  pop strobe; FIFO advances on the clk edge where it is high
- tx_data  out  WIDTH  outgoing word (registered)
- tx_valid  out  1  tx_data holds a word
- tx_sop  out  1  word is a header
- tx_eop  out  1  word is the last word of the message
- tx_ready  in  1  downstream accepts the word when tx_valid&tx_ready
- err_cnt  out  CNT_W  count of dropped malformed headers, saturating
- busy  out  1  high in PAYLOAD state or while tx_valid=1

## Operation
- States: HDR (expect header), PAYLOAD (rem>0 payload words outstanding). rem is LEN_W bits.
- slot_free = ~tx_valid | tx_ready.
- fifo_rd = ~reset & ~fifo_empty & (slot_free | (state==HDR & hdr_bad)), where hdr_bad = fifo_rdata[7:0]!=DELIM.
- fifo_rd must never be high while fifo_empty=1.
- HDR, pop, good header: load the output register with tx_sop=1. len=fifo_rdata[8+LEN_W-1:8].
  - len=0: tx_eop=1 and stay in HDR.
  - Otherwise: rem<=len, tx_eop=0, go to PAYLOAD.
- HDR, pop, bad header: the word is discarded and the output register is left untouched. err_cnt increments and stops at 2^CNT_W-1. A bad-header drop may occur while the output is stalled.
- PAYLOAD, pop: load the output register with tx_sop=0 and tx_eop=(rem==1). rem<=rem-1. Return to HDR when rem==1.
- Payload words are never delimiter-checked.
- Output register behaviour:
  - If tx_valid&tx_ready and no load occurs, tx_valid goes to 0.
  - While tx_valid&~tx_ready, tx_data, tx_sop and tx_eop must be held stable.
- Reset mid-message: the partial message is abandoned. The state returns to HDR and the next popped word is treated as a header.
- Reset values: tx_valid=0, tx_data=0, tx_sop=0, tx_eop=0, fifo_rd=0, err_cnt=0, busy=0, state=HDR, rem=0.

## Timing
- Latency: a word popped at edge N appears on tx_data with tx_valid=1 immediately after edge N.
- Throughput: one word per cycle when the FIFO is non-empty and tx_ready is held high. There are no bubbles between messages.
- fifo_rd is combinational from fifo_empty, fifo_rdata, tx_ready and state. There is no combinational path from tx_ready to tx_data.
- With tx_ready low and tx_valid=1, fifo_rd stays 0 except for bad-header drops. The FIFO keeps the next word at its head.
- err_cnt updates on the same edge as the drop pop.
- Asynchronous reset takes effect on outputs without waiting for a clock edge. fifo_rd is forced low while reset=1.

## Test plan
- Single message: FIFO holds {hdr len=2, P0, P1}, tx_ready=1.
  - Required: three consecutive cycles of tx_valid.
  - sop=1 on the header only; eop=1 on P1 only; fifo_rd high for exactly 3 cycles.
- Zero-length back-to-back: two headers with len=0, tx_ready=1.
  - Required: two consecutive beats, each with sop=1 and eop=1.
  - State stays HDR throughout.
- Backpressure: len=3 message, tx_ready low for 4 cycles mid-payload.
  - Required: tx_data, tx_sop and tx_eop are held; fifo_rd=0 during the stall.
  - All 4 words are delivered in order with no duplicates.
- Malformed header: FIFO holds {word[7:0]=8'h12, good hdr len=1, P0}.
  - Required: the first word is dropped and err_cnt=1.
  - The following message is emitted intact. err_cnt saturates at 16'hffff after forced overflow.
- Empty guard: FIFO drains mid-message (len=4, only 2 payload words present).
  - Required: fifo_rd stays 0 while fifo_empty=1 and busy=1.
  - The message resumes correctly when the remaining words are written.
- Reset mid-message: assert reset during PAYLOAD with rem=2.
  - Required: all outputs go to their reset values immediately.
  - The next word is parsed as a header.
